// File: rtl/regfile_wr_arbiter_pkg.sv
// Shared widths and the pending-write entry type for the
// register-file write-port arbiter.
package regfile_wr_arbiter_pkg;

    localparam int DATA_W     = 16;
    localparam int REG_ADDR_W = 3;
    localparam int NUM_REGS   = 8;

    typedef struct packed {
        logic [REG_ADDR_W-1:0] rd;
        logic [DATA_W-1:0]     data;
    } wr_entry_t;

endpackage

// File: rtl/regfile_wr_arbiter_wr_fifo.sv
// Small sync FIFO of pending secondary writes; exposes every slot
// and its valid bit so the top can build the busy mask.
module wr_fifo
    import regfile_wr_arbiter_pkg::*;
#(
    parameter int DEPTH = 2
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       push,
    input  wr_entry_t  wdata,
    input  logic       pop,
    output logic       full,
    output logic       empty,
    output wr_entry_t  head,
    output wr_entry_t  entries [DEPTH],
    output logic [DEPTH-1:0] valid
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic [CW-1:0] count;
    wr_entry_t     mem [DEPTH];

    always_ff @(negedge clk or posedge reset) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (pop)  rd_ptr <= rd_ptr + 1'b1;
            count <= count + CW'(push) - CW'(pop);
        end
    end

    // Payload needs no reset; stale slots are masked by valid.
    always_ff @(negedge clk) begin
        if (push) mem[wr_ptr] <= wdata;
    end

    assign full  = (count == CW'(DEPTH));
    assign empty = (count == '0);
    assign head  = mem[rd_ptr];

    always_comb begin
        logic [AW-1:0] off;
        valid = '0;
        off   = '0;
        for (int i = 0; i < DEPTH; i++) begin
            entries[i] = mem[i];
            off        = AW'(i) - rd_ptr;
            valid[i]   = ({1'b0, off} < count);
        end
    end

endmodule

// File: rtl/regfile_wr_arbiter.sv
// Shares the register-file write port between the writeback stage
// (always wins) and a buffered long-latency secondary producer.
module regfile_wr_arbiter
    import regfile_wr_arbiter_pkg::*;
#(
    parameter int DEPTH      = 2,
    parameter int STARVE_MAX = 4
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  p_valid,
    input  logic [REG_ADDR_W-1:0] p_rd,
    input  logic [DATA_W-1:0]     p_data,
    input  logic                  s_valid,
    output logic                  s_ready,
    input  logic [REG_ADDR_W-1:0] s_rd,
    input  logic [DATA_W-1:0]     s_data,
    output logic                  RegWr,
    output logic [REG_ADDR_W-1:0] Rd,
    output logic [DATA_W-1:0]     WBus,
    output logic [NUM_REGS-1:0]   busy_mask,
    output logic                  stall_req,
    output logic                  err_waw
);

    localparam int WW = $clog2(STARVE_MAX + 1);

    logic             full;
    logic             empty;
    logic             push;
    logic             pop;
    wr_entry_t        head;
    wr_entry_t        entries [DEPTH];
    logic [DEPTH-1:0] valid;
    logic [WW-1:0]    wait_cnt;

    assign s_ready = !full;
    assign push    = s_valid && s_ready;
    assign pop     = !p_valid && !empty;

    wr_fifo #(
        .DEPTH(DEPTH)
    ) u_fifo (
        .clk    (clk),
        .reset  (reset),
        .push   (push),
        .wdata  ('{rd: s_rd, data: s_data}),
        .pop    (pop),
        .full   (full),
        .empty  (empty),
        .head   (head),
        .entries(entries),
        .valid  (valid)
    );

    always_comb begin
        busy_mask = '0;
        for (int i = 0; i < DEPTH; i++) begin
            if (valid[i]) busy_mask[entries[i].rd] = 1'b1;
        end
    end

    assign stall_req = !empty && (wait_cnt == WW'(STARVE_MAX));

    always_ff @(negedge clk or posedge reset) begin
        if (reset) begin
            RegWr <= 1'b0;
            Rd    <= '0;
            WBus  <= '0;
        end else if (p_valid) begin
            RegWr <= 1'b1;
            Rd    <= p_rd;
            WBus  <= p_data;
        end else if (!empty) begin
            RegWr <= 1'b1;
            Rd    <= head.rd;
            WBus  <= head.data;
        end else begin
            RegWr <= 1'b0;
        end
    end

    // Counts consecutive edges on which a pending head lost to the primary.
    always_ff @(negedge clk or posedge reset) begin
        if (reset) begin
            wait_cnt <= '0;
        end else if (empty || pop) begin
            wait_cnt <= '0;
        end else if (wait_cnt != WW'(STARVE_MAX)) begin
            wait_cnt <= wait_cnt + 1'b1;
        end
    end

    always_ff @(negedge clk or posedge reset) begin
        if (reset) begin
            err_waw <= 1'b0;
        end else if (p_valid && busy_mask[p_rd]) begin
            err_waw <= 1'b1;
        end
    end

endmodule
